// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: decoupled RV32 instruction fetch with credit-limited requests,
// in-order response tracking, prefetch FIFO and redirect flush.
module rv_fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, rsp_pc_q, target;
    logic [ADDR_WIDTH-1:0] pc_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] dat_mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q, out_q, drop_q, cnt_d, out_d, drop_d;
    logic [CW:0] credit;
    logic fire, rsp_ok, push, pop;

    // Credits count FIFO slots already claimed by kept entries or kept in-flight responses
    assign credit = {1'b0, cnt_q} + {1'b0, out_q} - {1'b0, drop_q};
    assign imem_req_valid = rst_n && !redirect_valid && credit < (CW+1)'(FIFO_DEPTH);
    assign imem_req_addr = fetch_pc_q;
    assign target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign fire = imem_req_valid && imem_req_ready;
    assign rsp_ok = imem_rsp_valid && out_q != '0;
    assign push = rsp_ok && drop_q == '0 && !redirect_valid;
    assign pop = inst_valid && inst_ready && !redirect_valid;
    assign inst_valid = cnt_q != '0;
    assign inst_data = dat_mem_q[rd_q];
    assign inst_pc = pc_mem_q[rd_q];

    always_comb begin
        out_d = out_q + CW'(fire) - CW'(rsp_ok);
        drop_d = redirect_valid ? out_q - CW'(rsp_ok) : drop_q - CW'(rsp_ok && drop_q != '0);
        cnt_d = redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
            out_q <= '0;
            drop_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i] <= '0;
                dat_mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
            drop_q <= drop_d;
            if (redirect_valid) begin
                fetch_pc_q <= target;
                rsp_pc_q <= target;
                rd_q <= '0;
                wr_q <= '0;
            end else begin
                if (fire) fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(4);
                if (pop) rd_q <= rd_q + PW'(1);
                if (push) begin
                    pc_mem_q[wr_q] <= rsp_pc_q;
                    dat_mem_q[wr_q] <= imem_rsp_data;
                    wr_q <= wr_q + PW'(1);
                    rsp_pc_q <= rsp_pc_q + ADDR_WIDTH'(4);
                end
            end
        end
    end
endmodule

// File: tb/tb_rv_fetch_unit.sv
// tb_rv_fetch_unit: randomized and directed checks of rv_fetch_unit against an
// epoch-tagged transaction model of the memory and the expected instruction stream.
module tb_rv_fetch_unit;
    localparam int DEPTH = 4;
    localparam logic [31:0] RPC = 32'h0;

    logic clk = 0, rst_n = 0;
    logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
    logic [31:0] imem_req_addr, imem_rsp_data = 0, redirect_pc = 0;
    logic redirect_valid = 0, inst_valid, inst_ready = 0;
    logic [31:0] inst_data, inst_pc;

    rv_fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic [31:0] data; int epoch; int due;} req_t;
    typedef struct {logic [31:0] pc; logic [31:0] d;} ent_t;
    req_t mem_q[$];
    ent_t exp_q[$];
    int epoch = 0, cyc = 0, last_due = 0, fires = 0;
    int checks = 0, errors = 0;
    logic [31:0] mpc = RPC;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rr, input bit ir, input bit red, input logic [31:0] rpc,
                        input int lmin, input int lmax, input bit stray);
        bit rsp, ev;
        int inflight = 0;
        req_t h;
        ent_t e;
        @(negedge clk);
        rsp = mem_q.size() > 0 && mem_q[0].due <= cyc;
        foreach (mem_q[i]) if (mem_q[i].epoch == epoch) inflight++;
        imem_req_ready = rr;
        inst_ready = ir;
        redirect_valid = red;
        redirect_pc = rpc;
        imem_rsp_valid = rsp || stray;
        imem_rsp_data = rsp ? mem_q[0].data : $urandom;
        ev = rst_n && !red && (exp_q.size() + inflight < DEPTH);
        #1;
        chk("req_valid", imem_req_valid, ev);
        chk("req_addr", imem_req_addr, mpc);
        chk("inst_valid", inst_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("inst_pc", inst_pc, exp_q[0].pc);
            chk("inst_data", inst_data, exp_q[0].d);
        end else if (!rst_n) begin
            chk("rst_inst_pc", inst_pc, 0);
            chk("rst_inst_data", inst_data, 0);
        end
        if (rsp) h = mem_q.pop_front();
        if (rst_n) begin
            if (red) begin
                exp_q.delete();
                epoch++;
                mpc = {rpc[31:2], 2'b00};
            end else begin
                if (ir && exp_q.size() != 0) void'(exp_q.pop_front());
                if (rsp && h.epoch == epoch) begin
                    e.pc = h.addr;
                    e.d = h.data;
                    exp_q.push_back(e);
                end
                if (ev && rr) begin
                    h.addr = mpc;
                    h.data = $urandom;
                    h.epoch = epoch;
                    h.due = cyc + $urandom_range(lmax, lmin);
                    if (h.due <= last_due) h.due = last_due + 1;
                    last_due = h.due;
                    mem_q.push_back(h);
                    mpc += 4;
                    fires++;
                end
            end
        end
        cyc++;
    endtask

    task automatic run(input int n, input int prr, input int pir, input int pred, input int lmax);
        for (int k = 0; k < n; k++)
            step($urandom_range(99) < prr, $urandom_range(99) < pir, $urandom_range(99) < pred,
                 $urandom, 1, lmax, 0);
    endtask

    initial begin
        #3;
        chk("reset_req_valid", imem_req_valid, 0);
        chk("reset_inst_valid", inst_valid, 0);
        chk("reset_req_addr", imem_req_addr, RPC);
        chk("reset_inst_pc", inst_pc, 0);
        chk("reset_inst_data", inst_data, 0);
        @(negedge clk);
        rst_n = 1;
        // Streaming with single-cycle memory
        for (int k = 0; k < 20; k++) step(1, 1, 0, 0, 1, 1, 0);
        // Flush, then stall decode: exactly DEPTH requests, then one more per pop
        step(1, 0, 1, 32'h40, 1, 1, 0);
        fires = 0;
        for (int k = 0; k < 12; k++) step(1, 0, 0, 0, 1, 1, 0);
        chk("stall_fires", fires, DEPTH);
        chk("stall_head_pc", inst_pc, 32'h40);
        step(1, 1, 0, 0, 1, 1, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 1, 1, 0);
        chk("one_pop_fires", fires, DEPTH + 1);
        // Redirect with three 3-cycle responses in flight
        step(1, 1, 1, 32'h0, 1, 1, 0);
        for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 3, 3, 0);
        step(1, 1, 1, 32'h100, 1, 1, 0);
        for (int k = 0; k < 12; k++) step(1, 1, 0, 0, 1, 1, 0);
        // Unaligned redirect coinciding with response and pop
        step(1, 1, 1, 32'h203, 1, 1, 0);
        step(1, 1, 1, 32'h203, 1, 1, 0);
        for (int k = 0; k < 8; k++) step(1, 1, 0, 0, 1, 1, 0);
        // Stalled request withdrawn by redirect
        step(1, 1, 0, 0, 1, 2, 0);
        step(0, 1, 0, 0, 1, 2, 0);
        step(0, 1, 1, 32'h300, 1, 2, 0);
        step(1, 1, 0, 0, 1, 2, 0);
        chk("after_stall_redirect_addr", mpc, 32'h304);
        for (int k = 0; k < 8; k++) step(1, 1, 0, 0, 1, 2, 0);
        // Address wraparound
        step(1, 1, 1, 32'hFFFF_FFF4, 1, 1, 0);
        for (int k = 0; k < 12; k++) step(1, 1, 0, 0, 1, 1, 0);
        // Randomized traffic
        run(400, 70, 60, 5, 4);
        run(200, 90, 90, 15, 2);
        // Mid-operation reset with responses in flight
        step(1, 0, 1, 32'h500, 1, 1, 0);
        step(1, 0, 0, 0, 3, 3, 0);
        step(1, 0, 0, 0, 3, 3, 0);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("async_req_valid", imem_req_valid, 0);
        chk("async_inst_valid", inst_valid, 0);
        chk("async_req_addr", imem_req_addr, RPC);
        chk("async_inst_pc", inst_pc, 0);
        exp_q.delete();
        epoch++;
        mpc = RPC;
        step(0, 1, 0, 0, 1, 1, 0);
        rst_n = 1;
        for (int k = 0; k < 20 && mem_q.size() > 0; k++) step(0, 1, 0, 0, 1, 1, 0);
        chk("strays_drained", mem_q.size(), 0);
        // Response with nothing outstanding
        step(0, 1, 0, 0, 1, 1, 1);
        step(0, 1, 0, 0, 1, 1, 1);
        for (int k = 0; k < 30; k++) step(1, 1, 0, 0, 1, 2, 0);
        run(200, 80, 70, 8, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_fetch_unit.md
Name: rv_fetch_unit

Overview:
- Decoupled instruction-fetch stage for the next-generation pipelined RV32 core.
- Replaces the single-cycle PC counter to instruction-memory path.
- Issues sequential fetch requests to a variable-latency instruction memory and buffers returned instructions with their PCs in a parametrised prefetch FIFO.
- Hands instructions to decode over a valid/ready interface and flushes cleanly on branch/jump redirects from execute.

Parameters:
- ADDR_WIDTH, 32, width of PC and instruction-memory address.
- DATA_WIDTH, 32, instruction width.
- FIFO_DEPTH, 4, prefetch queue entries; power of two, ≥2; also the cap on in-flight requests.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  ADDR_WIDTH  word-aligned fetch address
- imem_rsp_valid  input  1  response valid; responses return in request order, latency ≥1 cycle
- imem_rsp_data  input  DATA_WIDTH  fetched instruction
- redirect_valid  input  1  branch/jump taken; flush and restart
- redirect_pc  input  ADDR_WIDTH  new fetch target
- inst_valid  output  1  FIFO head valid
- inst_ready  input  1  decode accepts head
- inst_data  output  DATA_WIDTH  head instruction
- inst_pc  output  ADDR_WIDTH  PC of head instruction

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0.
- Output values during reset:
  - imem_req_valid=0, inst_valid=0.
  - imem_req_addr=RESET_PC.
  - inst_data=0, inst_pc=0.
- State:
  - fetch_pc: next address to request.
  - rsp_pc: PC of the next non-dropped response.
  - outstanding: in-flight requests, width $clog2(FIFO_DEPTH+1).
  - drop_cnt: in-flight responses to discard.
  - FIFO of {pc, inst}.
- Request issue:
  - imem_req_valid = !redirect_valid && (fifo_count + outstanding - drop_cnt) < FIFO_DEPTH.
  - imem_req_addr = fetch_pc.
  - On req handshake: fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH) and outstanding++.
  - This credit rule guarantees every kept response has a FIFO slot, so push-when-full is impossible.
- Response:
  - On imem_rsp_valid: outstanding-- (handshake and response in the same cycle net to zero change).
  - If drop_cnt>0: discard the response and drop_cnt--.
  - Otherwise: push {rsp_pc, imem_rsp_data} and rsp_pc += 4.
  - imem_rsp_valid with outstanding==0 is a protocol violation and is ignored; no state change.
- Output:
  - inst_valid = FIFO non-empty; inst_data/inst_pc = head, registered storage, no combinational path from imem_rsp.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle both take effect; count is unchanged.
  - Minimum latency from request handshake to inst_valid: response latency + 1 cycle (response arriving at cycle N → inst_valid at N+1).
- Redirect (redirect_valid=1), which takes priority over all other events in that cycle:
  - FIFO cleared at the edge; any pop in that cycle is ignored.
  - No request issued.
  - fetch_pc and rsp_pc ← {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - drop_cnt ← outstanding - imem_rsp_valid; the response arriving in the redirect cycle is itself discarded.
  - outstanding ← outstanding - imem_rsp_valid.
  - First request to the new target is issued the following cycle.
- Back-to-back redirects: each restarts with recomputed drop_cnt; only the last target's instructions ever reach the FIFO.
- Request held with imem_req_ready=0: address stays stable, and valid stays asserted unless a redirect arrives (redirect may withdraw an un-accepted request).
- Reset mid-operation: all state returns to reset values immediately; any subsequent stray responses are ignored per the outstanding==0 rule.

Test Plan:
- Release reset, imem_req_ready=1, 1-cycle response, inst_ready=1 → requests 0x0,0x4,0x8…; inst_valid 2 cycles after first request; inst_pc/inst_data match in order with no bubbles at steady state.
- inst_ready=0, FIFO_DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0; inst_ready=1 for one cycle → one new request issued, head inst_pc=0x0 popped.
- 3-cycle memory latency with 3 requests in flight, redirect_pc=0x100 → 3 responses discarded (drop_cnt 3→0); first delivered inst_pc=0x100; no stale PC ever appears at inst_pc.
- redirect_pc=0x203 → fetch resumes at 0x200; redirect in the same cycle as a rsp_valid and an inst_ready pop → FIFO empty next cycle and that response dropped.
- imem_req_ready toggling 1,0,0,1 with redirect asserted during the stall → stalled address withdrawn; next request addr=redirect target.
- fetch_pc=0xFFFF_FFFC sequential fetch → next address 0x0000_0000; assert rst_n=0 with 2 responses in flight → outputs reset asynchronously; late responses do not push into the FIFO.
